ps2_key_decoder: RTL and testbench

- Sits directly downstream of the PS/2 byte receiver. Consumes its 8-bit scan-code bytes, qualified by the one-cycle done tick.
- Assembles Set-2 prefix sequences (E0 extended, F0 break, E1 pause) into complete key events. Tracks Shift and Caps Lock, and translates make codes to ASCII.
- Buffers events in a first-word-fall-through FIFO so the consumer (display/UART logic) can pop them at its own pace.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_ascii_rom.sv | 71 +++++++
 rtl/ps2_key_decoder.sv | 161 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event record for the PS/2 key decoder.
// Also holds the letter classifier used to choose the case rule.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        SKIP    = 3'd4
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] ascii;
    } key_event_t;

    // Letters follow Caps Lock; everything else follows Shift alone.
    function automatic logic is_letter(input logic [7:0] code);
        case (code)
            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Set-2 make code to ASCII lookup; each entry holds the {unshifted, shifted} pair.
module ps2_ascii_rom (
    input  logic [7:0] code,
    input  logic       upper,
    output logic [7:0] ascii
);

    logic [7:0] w_lo;
    logic [7:0] w_hi;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        {w_lo, w_hi} = 16'h0000;
        case (code)
            8'h1C: {w_lo, w_hi} = "aA";
            8'h32: {w_lo, w_hi} = "bB";
            8'h21: {w_lo, w_hi} = "cC";
            8'h23: {w_lo, w_hi} = "dD";
            8'h24: {w_lo, w_hi} = "eE";
            8'h2B: {w_lo, w_hi} = "fF";
            8'h34: {w_lo, w_hi} = "gG";
            8'h33: {w_lo, w_hi} = "hH";
            8'h43: {w_lo, w_hi} = "iI";
            8'h3B: {w_lo, w_hi} = "jJ";
            8'h42: {w_lo, w_hi} = "kK";
            8'h4B: {w_lo, w_hi} = "lL";
            8'h3A: {w_lo, w_hi} = "mM";
            8'h31: {w_lo, w_hi} = "nN";
            8'h44: {w_lo, w_hi} = "oO";
            8'h4D: {w_lo, w_hi} = "pP";
            8'h15: {w_lo, w_hi} = "qQ";
            8'h2D: {w_lo, w_hi} = "rR";
            8'h1B: {w_lo, w_hi} = "sS";
            8'h2C: {w_lo, w_hi} = "tT";
            8'h3C: {w_lo, w_hi} = "uU";
            8'h2A: {w_lo, w_hi} = "vV";
            8'h1D: {w_lo, w_hi} = "wW";
            8'h22: {w_lo, w_hi} = "xX";
            8'h35: {w_lo, w_hi} = "yY";
            8'h1A: {w_lo, w_hi} = "zZ";
            8'h45: {w_lo, w_hi} = "0)";
            8'h16: {w_lo, w_hi} = "1!";
            8'h1E: {w_lo, w_hi} = "2@";
            8'h26: {w_lo, w_hi} = "3#";
            8'h25: {w_lo, w_hi} = "4$";
            8'h2E: {w_lo, w_hi} = "5%";
            8'h36: {w_lo, w_hi} = "6^";
            8'h3D: {w_lo, w_hi} = "7&";
            8'h3E: {w_lo, w_hi} = "8*";
            8'h46: {w_lo, w_hi} = "9(";
            8'h0E: {w_lo, w_hi} = "`~";
            8'h4E: {w_lo, w_hi} = "-_";
            8'h55: {w_lo, w_hi} = "=+";
            8'h54: {w_lo, w_hi} = "[{";
            8'h5B: {w_lo, w_hi} = "]}";
            8'h5D: {w_lo, w_hi} = {8'h5C, 8'h7C};
            8'h4C: {w_lo, w_hi} = ";:";
            8'h52: {w_lo, w_hi} = {8'h27, 8'h22};
            8'h41: {w_lo, w_hi} = ",<";
            8'h49: {w_lo, w_hi} = ".>";
            8'h4A: {w_lo, w_hi} = "/?";
            8'h29: {w_lo, w_hi} = 16'h2020;
            8'h5A: {w_lo, w_hi} = 16'h0D0D;
            8'h66: {w_lo, w_hi} = 16'h0808;
            default: {w_lo, w_hi} = 16'h0000;
        endcase
    end

    assign ascii = upper ? w_hi : w_lo;

endmodule

// File: rtl/ps2_key_decoder.sv
// Assembles Set-2 scan-code sequences into key events, tracks Shift/Caps Lock,
// and queues events in a first-word-fall-through FIFO.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] din,
    input  logic       rd,
    output logic       empty,
    output logic       full,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic [7:0] ascii,
    output logic       caps_lock,
    output logic       overflow
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_skip, w_skip_nxt;
    logic       w_push, w_ext, w_brk;
    logic       r_shift_l, r_shift_r, r_caps, r_overflow;
    logic       w_upper;
    logic [7:0] w_rom_ascii;
    key_event_t w_event, w_head;

    key_event_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_rd_en, w_wr_en;

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_push      = 1'b0;
        w_ext       = 1'b0;
        w_brk       = 1'b0;
        if (rx_done_tick) begin
            case (r_state)
                IDLE: begin
                    if (din == SC_EXT) begin
                        w_state_nxt = EXT;
                    end else if (din == SC_BRK) begin
                        w_state_nxt = BRK;
                    end else if (din == SC_PAUSE) begin
                        w_state_nxt = SKIP;
                        w_skip_nxt  = 3'd7;
                    end else if (din != SC_BAT && din != SC_ACK) begin
                        w_push = 1'b1;
                    end
                end
                EXT: begin
                    if (din == SC_BRK) begin
                        w_state_nxt = EXT_BRK;
                    end else if (din != SC_EXT) begin
                        w_push      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                BRK: begin
                    w_push      = 1'b1;
                    w_brk       = 1'b1;
                    w_state_nxt = IDLE;
                end
                EXT_BRK: begin
                    w_push      = 1'b1;
                    w_ext       = 1'b1;
                    w_brk       = 1'b1;
                    w_state_nxt = IDLE;
                end
                SKIP: begin
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip == 3'd1) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_skip  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    // ASCII uses the modifier state from before this event's own update.
    assign w_upper = is_letter(din) ? ((r_shift_l | r_shift_r) ^ r_caps)
                                    : (r_shift_l | r_shift_r);

    ps2_ascii_rom u_rom (
        .code  (din),
        .upper (w_upper),
        .ascii (w_rom_ascii)
    );

    assign w_event = '{ext: w_ext, brk: w_brk, code: din,
                       ascii: (w_ext | w_brk) ? 8'h00 : w_rom_ascii};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift_l <= 1'b0;
            r_shift_r <= 1'b0;
            r_caps    <= 1'b0;
        end else if (w_push && !w_ext) begin
            if (din == SC_LSHIFT) r_shift_l <= !w_brk;
            if (din == SC_RSHIFT) r_shift_r <= !w_brk;
            if (din == SC_CAPS && !w_brk) r_caps <= !r_caps;
        end
    end

    assign empty   = (r_count == '0);
    assign full    = (r_count == FULL_CNT);
    assign w_rd_en = rd && !empty;
    assign w_wr_en = w_push && (!full || w_rd_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_wr_en) r_overflow <= 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; stale entries are never visible because outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_event;
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign key_code  = empty ? 8'h00 : w_head.code;
    assign key_ext   = empty ? 1'b0  : w_head.ext;
    assign key_brk   = empty ? 1'b0  : w_head.brk;
    assign ascii     = empty ? 8'h00 : w_head.ascii;
    assign caps_lock = r_caps;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and randomized bench for ps2_key_decoder against a sequence-level
// reference model (byte-string parsing, lookup tables and an event queue).
module tb_ps2_key_decoder;

    localparam int DEPTH = 8;

    logic       clk;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] din;
    logic       rd;
    logic       empty, full, key_ext, key_brk, caps_lock, overflow;
    logic [7:0] key_code, ascii;

    ps2_key_decoder #(.DEPTH(DEPTH), .AW(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .din          (din),
        .rd           (rd),
        .empty        (empty),
        .full         (full),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_brk      (key_brk),
        .ascii        (ascii),
        .caps_lock    (caps_lock),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] asc;
    } ev_t;

    ev_t        q[$];
    logic [7:0] pend[$];
    bit         m_shl, m_shr, m_caps, m_ovf;
    logic [7:0] letter_idx [logic [7:0]];
    logic [7:0] lo_map [logic [7:0]];
    logic [7:0] hi_map [logic [7:0]];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    function automatic void build_tables();
        logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
            8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15,
            8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] others [21] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
            8'h3D, 8'h3E, 8'h46, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C,
            8'h52, 8'h41, 8'h49, 8'h4A};
        logic [7:0] lo_v [21] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
            8'h37, 8'h38, 8'h39, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B,
            8'h27, 8'h2C, 8'h2E, 8'h2F};
        logic [7:0] hi_v [21] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
            8'h26, 8'h2A, 8'h28, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A,
            8'h22, 8'h3C, 8'h3E, 8'h3F};
        for (int i = 0; i < 26; i++) letter_idx[letters[i]] = 8'(i);
        for (int i = 0; i < 21; i++) begin
            lo_map[others[i]] = lo_v[i];
            hi_map[others[i]] = hi_v[i];
        end
        lo_map[8'h29] = 8'h20; hi_map[8'h29] = 8'h20;
        lo_map[8'h5A] = 8'h0D; hi_map[8'h5A] = 8'h0D;
        lo_map[8'h66] = 8'h08; hi_map[8'h66] = 8'h08;
    endfunction

    // Parse the pending byte string; returns 1 when it forms a complete event.
    function automatic bit decode(input logic [7:0] b, output ev_t ev);
        int  i;
        bit  shift;
        logic [7:0] c;
        ev = '0;
        pend.push_back(b);
        if (pend[0] == 8'hE1) begin
            if (pend.size() == 8) pend.delete();
            return 1'b0;
        end
        i = 0;
        while (i < pend.size() && pend[i] == 8'hE0) begin ev.ext = 1'b1; i++; end
        if (i < pend.size() && pend[i] == 8'hF0) begin ev.brk = 1'b1; i++; end
        if (i >= pend.size()) return 1'b0;
        c = pend[i];
        pend.delete();
        if (!ev.ext && !ev.brk && (c == 8'hAA || c == 8'hFA)) return 1'b0;
        ev.code = c;
        shift = m_shl | m_shr;
        if (ev.ext || ev.brk)            ev.asc = 8'h00;
        else if (letter_idx.exists(c))   ev.asc = ((shift ^ m_caps) ? 8'h41 : 8'h61) + letter_idx[c];
        else if (lo_map.exists(c))       ev.asc = shift ? hi_map[c] : lo_map[c];
        else                             ev.asc = 8'h00;
        if (!ev.ext) begin
            if (c == 8'h12) m_shl = !ev.brk;
            if (c == 8'h59) m_shr = !ev.brk;
            if (c == 8'h58 && !ev.brk) m_caps = !m_caps;
        end
        return 1'b1;
    endfunction

    function automatic void model_edge(input bit tick, input logic [7:0] b, input bit r);
        bit  pop, have;
        ev_t ev;
        pop  = r && (q.size() > 0);
        have = 1'b0;
        ev   = '0;
        if (tick) have = decode(b, ev);
        if (pop) void'(q.pop_front());
        if (have) begin
            if (q.size() < DEPTH) q.push_back(ev);
            else m_ovf = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        pend.delete();
        m_shl = 0; m_shr = 0; m_caps = 0; m_ovf = 0;
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        ev_t h;
        h = (q.size() > 0) ? q[0] : '0;
        chk1({tag, " empty"},     empty,     q.size() == 0);
        chk1({tag, " full"},      full,      q.size() == DEPTH);
        chk8({tag, " key_code"},  key_code,  h.code);
        chk1({tag, " key_ext"},   key_ext,   h.ext);
        chk1({tag, " key_brk"},   key_brk,   h.brk);
        chk8({tag, " ascii"},     ascii,     h.asc);
        chk1({tag, " caps_lock"}, caps_lock, m_caps);
        chk1({tag, " overflow"},  overflow,  m_ovf);
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic step(input string tag, input bit tick, input logic [7:0] b, input bit r);
        rx_done_tick = tick;
        din          = b;
        rd           = r;
        @(posedge clk);
        model_edge(tick, b, r);
        @(negedge clk);
        rx_done_tick = 1'b0;
        rd           = 1'b0;
        check_all(tag);
    endtask

    task automatic send(input string tag, input logic [7:0] b);
        step(tag, 1'b1, b, 1'b0);
    endtask

    task automatic pop(input string tag);
        step(tag, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) pop(tag);
    endtask

    logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h12, 8'h59, 8'h58,
                              8'h1C, 8'h32, 8'h16, 8'h45, 8'h4E, 8'h29, 8'h5A, 8'h75};

    initial begin
        build_tables();
        model_reset();
        reset = 1'b0; rx_done_tick = 1'b0; din = 8'h00; rd = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b1;

        // Single make, one-cycle latency.
        chk1("t1 empty before", empty, 1'b1);
        send("t1 1C", 8'h1C);
        chk8("t1 ascii const", ascii, 8'h61);
        drain("t1 drain");

        // Shifted letter, break, shift release.
        send("t2 12", 8'h12);
        send("t2 1C", 8'h1C);
        send("t2 F0", 8'hF0);
        send("t2 1C brk", 8'h1C);
        send("t2 F0b", 8'hF0);
        send("t2 12 brk", 8'h12);
        pop("t2 pop1");
        chk8("t2 shifted A", ascii, 8'h41);
        pop("t2 pop2");
        chk1("t2 brk flag", key_brk, 1'b1);
        chk8("t2 brk ascii", ascii, 8'h00);
        drain("t2 drain");

        // Caps Lock, then Shift cancels it for letters.
        send("t3 58", 8'h58);
        send("t3 F0", 8'hF0);
        send("t3 58 brk", 8'h58);
        chk1("t3 caps on", caps_lock, 1'b1);
        send("t3 1C", 8'h1C);
        pop("t3 pop1");
        pop("t3 pop2");
        chk8("t3 caps A", ascii, 8'h41);
        drain("t3 drain");
        send("t3 12", 8'h12);
        send("t3 1C b", 8'h1C);
        pop("t3 pop3");
        chk8("t3 caps+shift a", ascii, 8'h61);
        drain("t3 drain2");
        send("t3 F0c", 8'hF0);
        send("t3 12 brk", 8'h12);
        send("t3 58 off", 8'h58);
        drain("t3 drain3");

        // Extended make/break and Pause sequence.
        send("t4 E0", 8'hE0);
        send("t4 75", 8'h75);
        chk1("t4 ext", key_ext, 1'b1);
        chk8("t4 ext ascii", ascii, 8'h00);
        send("t4 E0b", 8'hE0);
        send("t4 F0", 8'hF0);
        send("t4 75 brk", 8'h75);
        pop("t4 pop");
        chk1("t4 ext brk", key_brk, 1'b1);
        drain("t4 drain");
        foreach (pool[k]) begin end
        send("t4 pause0", 8'hE1); send("t4 pause1", 8'h14); send("t4 pause2", 8'h77);
        send("t4 pause3", 8'hE1); send("t4 pause4", 8'hF0); send("t4 pause5", 8'h14);
        send("t4 pause6", 8'hF0); send("t4 pause7", 8'h77);
        chk1("t4 pause no event", empty, 1'b1);
        send("t4 1C after", 8'h1C);
        chk8("t4 1C code", key_code, 8'h1C);
        drain("t4 drain2");

        // Fill, overflow, simultaneous push/pop while full.
        for (int i = 0; i < 8; i++) send("t5 fill", 8'h1C);
        chk1("t5 full", full, 1'b1);
        send("t5 ninth", 8'h1C);
        chk1("t5 overflow", overflow, 1'b1);
        step("t5 push+pop", 1'b1, 8'h32, 1'b1);
        chk1("t5 still full", full, 1'b1);
        for (int i = 0; i < 7; i++) pop("t5 order");
        chk8("t5 last code", key_code, 8'h32);
        drain("t5 drain");
        step("t5 pop+push empty", 1'b1, 8'h16, 1'b1);
        chk1("t5 not empty", empty, 1'b0);
        drain("t5 drain2");

        // Reset mid-sequence discards the partial prefix.
        send("t6 E0", 8'hE0);
        send("t6 F0", 8'hF0);
        reset = 1'b0;
        #2;
        model_reset();
        check_all("t6 in reset");
        @(negedge clk);
        reset = 1'b1;
        send("t6 1C", 8'h1C);
        chk1("t6 ext clear", key_ext, 1'b0);
        chk1("t6 brk clear", key_brk, 1'b0);
        drain("t6 drain");

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic [7:0] b;
            bit tick, r;
            b    = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 15)] : 8'($urandom_range(0, 255));
            tick = ($urandom_range(0, 9) < 6);
            r    = ($urandom_range(0, 9) < 4);
            step("rand", tick, b, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
